// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA read engine slice.
package dma_pkg;

  localparam int unsigned DATA_W    = 128;
  localparam int unsigned ADDR_W    = 32;
  // Descriptor length is stored at full width so the struct is independent
  // of the engine's LEN_W parameter; LEN_W must not exceed this.
  localparam int unsigned LEN_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [LEN_MAX_W-1:0] len;
  } desc_t;

  // Word address of beat 'offs' of a descriptor; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0]    base,
                                                  input logic [LEN_MAX_W-1:0] offs);
    return base + ADDR_W'(offs);
  endfunction

endpackage

// File: rtl/dma_rd_fifo.sv
// Synchronous show-ahead FIFO with occupancy count. Head entry is visible
// on rd_data_o whenever empty_o is low. A write is accepted while full only
// if a read happens in the same cycle.
module dma_rd_fifo #(
  parameter int unsigned WIDTH = 129,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push, pop;

  assign pop  = rd_en_i & (count_q != '0);
  assign push = wr_en_i & ((count_q != (PTR_W+1)'(DEPTH)) | pop);

  // Pointer and occupancy tracking; flushed by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/dma_rd_engine.sv
// Descriptor-driven RAM read engine. Accepts (addr, len), issues word reads,
// absorbs the one-cycle RAM latency and streams 128-bit beats with a last
// flag. Reads are credit-limited by the output FIFO so it never overflows.
// Optional statistics outputs (stall_cnt, beat_cnt) when DMA_RD_STATS_EN is
// defined.
module dma_rd_engine
  import dma_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [ADDR_W-1:0] desc_addr,
  input  logic [LEN_W-1:0]  desc_len,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              done,
`ifdef DMA_RD_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       beat_cnt,
`endif
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FW    = DATA_W + 1;

  state_e            state_q, state_d;
  desc_t             desc_q, desc_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              done_q, done_d;
  logic              inflight_q, inflight_last_q;

  logic              issue;
  logic              last_issue;
  logic              pop;
  logic              credit_ok;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W:0]    used;

  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [FW-1:0]     fifo_rd_data;

  assign cur_addr   = beat_addr(desc_q.addr, LEN_MAX_W'(issued_q));
  assign last_issue = (LEN_MAX_W'(issued_q) == (desc_q.len - LEN_MAX_W'(1)));

  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;

  // A slot freed by this cycle's pop is reusable immediately: the read
  // issued now lands in the FIFO two edges later, after the pop retires.
  assign used      = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign credit_ok = (used < (CNT_W+1)'(FIFO_DEPTH));

  dma_rd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (inflight_q),
    .wr_data_i ({inflight_last_q, ram_rd_data}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Next-state, read issue and completion logic.
  always_comb begin
    state_d   = state_q;
    desc_d    = desc_q;
    issued_d  = issued_q;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (desc_valid) begin
          desc_d.addr = desc_addr;
          desc_d.len  = LEN_MAX_W'(desc_len);
          issued_d    = '0;
          if (desc_len == '0) done_d  = 1'b1;
          else                state_d = RUN;
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue     = 1'b1;
          rd_addr_d = cur_addr;
          issued_d  = issued_q + LEN_W'(1);
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_rd_data[DATA_W]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine state; reset also drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      desc_q          <= '0;
      issued_q        <= '0;
      rd_addr_q       <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      desc_q          <= desc_d;
      issued_q        <= issued_d;
      rd_addr_q       <= rd_addr_d;
      done_q          <= done_d;
      inflight_q      <= issue;
      inflight_last_q <= issue & last_issue;
    end
  end

  assign desc_ready  = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign ram_rd_en   = issue;
  assign ram_rd_addr = issue ? cur_addr : rd_addr_q;
  assign m_data      = fifo_empty ? '0 : fifo_rd_data[DATA_W-1:0];
  assign m_last      = ~fifo_empty & fifo_rd_data[DATA_W];

`ifdef DMA_RD_STATS_EN
  logic [31:0] stall_q, beat_q;

  // Cumulative saturating stall and accepted-beat counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      beat_q  <= '0;
    end else begin
      if (m_valid && !m_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (pop && (beat_q != '1))                  beat_q  <= beat_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign beat_cnt  = beat_q;
`endif

endmodule

// File: tb/tb_dma_rd_engine.sv
// Directed self-checking bench for dma_rd_engine.
module tb_dma_rd_engine;

  logic         clk;
  logic         rst_n;
  logic         desc_valid;
  logic         desc_ready;
  logic [31:0]  desc_addr;
  logic [15:0]  desc_len;
  logic         ram_rd_en;
  logic [31:0]  ram_rd_addr;
  logic [127:0] ram_rd_data;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         m_last;
  logic         done;
  logic         busy;
`ifdef DMA_RD_STATS_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  beat_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0]  iss_addr[$];
  int           iss_cyc[$];
  logic [127:0] bt_data[$];
  logic         bt_last[$];
  int           bt_cyc[$];
  int           done_cyc_q[$];
  int           unstable = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic         prev_last;

  dma_rd_engine #(
    .FIFO_DEPTH (4),
    .LEN_W      (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .desc_valid  (desc_valid),
    .desc_ready  (desc_ready),
    .desc_addr   (desc_addr),
    .desc_len    (desc_len),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .done        (done),
`ifdef DMA_RD_STATS_EN
    .stall_cnt   (stall_cnt),
    .beat_cnt    (beat_cnt),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word content as a function of its address.
  function automatic logic [127:0] ram_word(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a, a + 32'h1234_5678, a};
  endfunction

  // RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= ram_word(ram_rd_addr);
  end

  // Record issues, accepted beats, done pulses and stalled-beat stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_rd_en) begin
        iss_addr.push_back(ram_rd_addr);
        iss_cyc.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        bt_data.push_back(m_data);
        bt_last.push_back(m_last);
        bt_cyc.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
        unstable++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_mon();
    iss_addr.delete();
    iss_cyc.delete();
    bt_data.delete();
    bt_last.delete();
    bt_cyc.delete();
    done_cyc_q.delete();
  endtask

  task automatic send_desc(input logic [31:0] a, input logic [15:0] l, output int acc);
    int  n = 0;
    bit  ok = 0;
    desc_valid = 1'b1;
    desc_addr  = a;
    desc_len   = l;
    while (!ok && n < 60) begin
      if (desc_ready) ok = 1;
      @(posedge clk); #1;
      n++;
    end
    desc_valid = 1'b0;
    acc = cyc;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL desc_accept timeout: desc_ready never seen, required 1");
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cyc_q.size() < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cyc_q.size() < target) begin
      n_checks++; n_fail++;
      $display("FAIL %s done_timeout: got %0d done pulses, required %0d", name, done_cyc_q.size(), target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; desc_valid = 1'b0; desc_addr = '0; desc_len = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (desc_ready !== 1'b1)   begin n_fail++; $display("FAIL rst desc_ready: got %b, required 1", desc_ready); end
    n_checks++; if (ram_rd_en !== 1'b0)    begin n_fail++; $display("FAIL rst ram_rd_en: got %b, required 0", ram_rd_en); end
    n_checks++; if (ram_rd_addr !== 32'h0) begin n_fail++; $display("FAIL rst ram_rd_addr: got %h, required 0", ram_rd_addr); end
    n_checks++; if (m_valid !== 1'b0)      begin n_fail++; $display("FAIL rst m_valid: got %b, required 0", m_valid); end
    n_checks++; if (m_data !== 128'h0)     begin n_fail++; $display("FAIL rst m_data: got %h, required 0", m_data); end
    n_checks++; if (m_last !== 1'b0)       begin n_fail++; $display("FAIL rst m_last: got %b, required 0", m_last); end
    n_checks++; if (done !== 1'b0)         begin n_fail++; $display("FAIL rst done: got %b, required 0", done); end
    n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL rst busy: got %b, required 0", busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int acc;
    clear_mon();
    m_ready = 1'b1;
    send_desc(32'h10, 16'd4, acc);
    wait_done(1, 40, "basic");
    n_checks++; if (iss_addr.size() != 4) begin n_fail++; $display("FAIL basic n_issue: got %0d, required 4", iss_addr.size()); end
    for (int i = 0; i < iss_addr.size() && i < 4; i++) begin
      n_checks++; if (iss_addr[i] !== 32'h10 + i) begin n_fail++; $display("FAIL basic addr[%0d]: got %h, required %h", i, iss_addr[i], 32'h10 + i); end
      n_checks++; if (iss_cyc[i] != acc + i) begin n_fail++; $display("FAIL basic issue_cyc[%0d]: got %0d, required %0d", i, iss_cyc[i], acc + i); end
    end
    n_checks++; if (bt_data.size() != 4) begin n_fail++; $display("FAIL basic n_beat: got %0d, required 4", bt_data.size()); end
    for (int i = 0; i < bt_data.size() && i < 4; i++) begin
      n_checks++; if (bt_data[i] !== ram_word(32'h10 + i)) begin n_fail++; $display("FAIL basic data[%0d]: got %h, required %h", i, bt_data[i], ram_word(32'h10 + i)); end
      n_checks++; if (bt_last[i] !== (i == 3)) begin n_fail++; $display("FAIL basic last[%0d]: got %b, required %b", i, bt_last[i], i == 3); end
      n_checks++; if (bt_cyc[i] != acc + 2 + i) begin n_fail++; $display("FAIL basic beat_cyc[%0d]: got %0d, required %0d", i, bt_cyc[i], acc + 2 + i); end
    end
    n_checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != acc + 6) begin n_fail++; $display("FAIL basic done_cyc: got n=%0d, required one pulse at %0d", done_cyc_q.size(), acc + 6); end
    n_checks++; if (ram_rd_en !== 1'b0 || ram_rd_addr !== 32'h13) begin n_fail++; $display("FAIL basic addr_hold: got en=%b addr=%h, required en=0 addr=00000013", ram_rd_en, ram_rd_addr); end
  endtask

  task automatic test_backpressure();
    int acc;
    int n = 0;
`ifdef DMA_RD_STATS_EN
    logic [31:0] st0, bc0;
    st0 = stall_cnt;
    bc0 = beat_cnt;
`endif
    clear_mon();
    unstable = 0;
    m_ready = 1'b0;
    send_desc(32'h40, 16'd8, acc);
    while (!m_valid && n < 20) begin @(posedge clk); #1; n++; end
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp m_valid_rise: got %b, required 1", m_valid); end
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (iss_addr.size() != 4) begin n_fail++; $display("FAIL bp issues_while_stalled: got %0d, required 4", iss_addr.size()); end
    m_ready = 1'b1;
    wait_done(1, 60, "bp");
    n_checks++; if (iss_addr.size() != 8) begin n_fail++; $display("FAIL bp n_issue: got %0d, required 8", iss_addr.size()); end
    for (int i = 0; i < iss_addr.size() && i < 8; i++) begin
      n_checks++; if (iss_addr[i] !== 32'h40 + i) begin n_fail++; $display("FAIL bp addr[%0d]: got %h, required %h", i, iss_addr[i], 32'h40 + i); end
    end
    n_checks++; if (bt_data.size() != 8) begin n_fail++; $display("FAIL bp n_beat: got %0d, required 8", bt_data.size()); end
    for (int i = 0; i < bt_data.size() && i < 8; i++) begin
      n_checks++; if (bt_data[i] !== ram_word(32'h40 + i)) begin n_fail++; $display("FAIL bp data[%0d]: got %h, required %h", i, bt_data[i], ram_word(32'h40 + i)); end
      n_checks++; if (bt_last[i] !== (i == 7)) begin n_fail++; $display("FAIL bp last[%0d]: got %b, required %b", i, bt_last[i], i == 7); end
    end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL bp stall_stability: got %0d changes, required 0", unstable); end
`ifdef DMA_RD_STATS_EN
    n_checks++; if (stall_cnt - st0 !== 32'd10) begin n_fail++; $display("FAIL bp stall_cnt: got %0d, required 10", stall_cnt - st0); end
    n_checks++; if (beat_cnt - bc0 !== 32'd8) begin n_fail++; $display("FAIL bp beat_cnt: got %0d, required 8", beat_cnt - bc0); end
`endif
  endtask

  task automatic test_zero_len();
    int acc;
    clear_mon();
    m_ready = 1'b1;
    send_desc(32'h100, 16'd0, acc);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (desc_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zlen idle[%0d]: got ready=%b busy=%b, required ready=1 busy=0", i, desc_ready, busy); end
      @(posedge clk); #1;
    end
    n_checks++; if (iss_addr.size() != 0) begin n_fail++; $display("FAIL zlen n_issue: got %0d, required 0", iss_addr.size()); end
    n_checks++; if (bt_data.size() != 0) begin n_fail++; $display("FAIL zlen n_beat: got %0d, required 0", bt_data.size()); end
    n_checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != acc) begin n_fail++; $display("FAIL zlen done: got n=%0d, required one pulse at %0d", done_cyc_q.size(), acc); end
  endtask

  task automatic test_wrap();
    int acc;
    logic [31:0] exp_a [3];
    exp_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    clear_mon();
    m_ready = 1'b1;
    send_desc(32'hFFFF_FFFE, 16'd3, acc);
    wait_done(1, 40, "wrap");
    n_checks++; if (iss_addr.size() != 3) begin n_fail++; $display("FAIL wrap n_issue: got %0d, required 3", iss_addr.size()); end
    for (int i = 0; i < iss_addr.size() && i < 3; i++) begin
      n_checks++; if (iss_addr[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap addr[%0d]: got %h, required %h", i, iss_addr[i], exp_a[i]); end
    end
    n_checks++; if (bt_data.size() != 3) begin n_fail++; $display("FAIL wrap n_beat: got %0d, required 3", bt_data.size()); end
    for (int i = 0; i < bt_data.size() && i < 3; i++) begin
      n_checks++; if (bt_data[i] !== ram_word(exp_a[i])) begin n_fail++; $display("FAIL wrap data[%0d]: got %h, required %h", i, bt_data[i], ram_word(exp_a[i])); end
      n_checks++; if (bt_last[i] !== (i == 2)) begin n_fail++; $display("FAIL wrap last[%0d]: got %b, required %b", i, bt_last[i], i == 2); end
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    logic [31:0] exp_a [5];
    int          exp_c [5];
    exp_a = '{32'h200, 32'h201, 32'h300, 32'h301, 32'h302};
    clear_mon();
    m_ready = 1'b1;
    send_desc(32'h200, 16'd2, acc1);
    send_desc(32'h300, 16'd3, acc2);
    wait_done(2, 40, "b2b");
    exp_c = '{acc1 + 2, acc1 + 3, acc2 + 2, acc2 + 3, acc2 + 4};
    n_checks++; if (acc2 != acc1 + 5) begin n_fail++; $display("FAIL b2b accept2_cyc: got %0d, required %0d", acc2, acc1 + 5); end
    n_checks++; if (bt_data.size() != 5) begin n_fail++; $display("FAIL b2b n_beat: got %0d, required 5", bt_data.size()); end
    for (int i = 0; i < bt_data.size() && i < 5; i++) begin
      n_checks++; if (bt_data[i] !== ram_word(exp_a[i])) begin n_fail++; $display("FAIL b2b data[%0d]: got %h, required %h", i, bt_data[i], ram_word(exp_a[i])); end
      n_checks++; if (bt_last[i] !== (i == 1 || i == 4)) begin n_fail++; $display("FAIL b2b last[%0d]: got %b, required %b", i, bt_last[i], i == 1 || i == 4); end
      n_checks++; if (bt_cyc[i] != exp_c[i]) begin n_fail++; $display("FAIL b2b beat_cyc[%0d]: got %0d, required %0d", i, bt_cyc[i], exp_c[i]); end
    end
    n_checks++; if (done_cyc_q.size() != 2) begin n_fail++; $display("FAIL b2b n_done: got %0d, required 2", done_cyc_q.size()); end
    else begin
      n_checks++; if (done_cyc_q[0] != acc1 + 4 || done_cyc_q[1] != acc2 + 5) begin n_fail++; $display("FAIL b2b done_cyc: got %0d,%0d, required %0d,%0d", done_cyc_q[0], done_cyc_q[1], acc1 + 4, acc2 + 5); end
    end
  endtask

  task automatic test_reset_mid_run();
    int acc;
    clear_mon();
    m_ready = 1'b0;
    send_desc(32'h500, 16'd8, acc);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (m_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mrst pre_state: got valid=%b busy=%b, required 1,1", m_valid, busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (desc_ready !== 1'b1)   begin n_fail++; $display("FAIL mrst desc_ready: got %b, required 1", desc_ready); end
    n_checks++; if (ram_rd_en !== 1'b0)    begin n_fail++; $display("FAIL mrst ram_rd_en: got %b, required 0", ram_rd_en); end
    n_checks++; if (ram_rd_addr !== 32'h0) begin n_fail++; $display("FAIL mrst ram_rd_addr: got %h, required 0", ram_rd_addr); end
    n_checks++; if (m_valid !== 1'b0)      begin n_fail++; $display("FAIL mrst m_valid: got %b, required 0", m_valid); end
    n_checks++; if (m_data !== 128'h0)     begin n_fail++; $display("FAIL mrst m_data: got %h, required 0", m_data); end
    n_checks++; if (m_last !== 1'b0)       begin n_fail++; $display("FAIL mrst m_last: got %b, required 0", m_last); end
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mrst done_busy: got %b,%b, required 0,0", done, busy); end
`ifdef DMA_RD_STATS_EN
    n_checks++; if (stall_cnt !== 32'd0 || beat_cnt !== 32'd0) begin n_fail++; $display("FAIL mrst stats: got %0d,%0d, required 0,0", stall_cnt, beat_cnt); end
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mrst stale_push: got m_valid=%b, required 0", m_valid); end
    clear_mon();
    m_ready = 1'b1;
    send_desc(32'h600, 16'd2, acc);
    wait_done(1, 40, "mrst");
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bt_data.size() != 2) begin n_fail++; $display("FAIL mrst n_beat: got %0d, required 2", bt_data.size()); end
    for (int i = 0; i < bt_data.size() && i < 2; i++) begin
      n_checks++; if (bt_data[i] !== ram_word(32'h600 + i)) begin n_fail++; $display("FAIL mrst data[%0d]: got %h, required %h", i, bt_data[i], ram_word(32'h600 + i)); end
      n_checks++; if (bt_last[i] !== (i == 1)) begin n_fail++; $display("FAIL mrst last[%0d]: got %b, required %b", i, bt_last[i], i == 1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dma_rd_engine.md
# dma_rd_engine

Descriptor-driven read engine sitting directly downstream of the simulation word RAM: accepts a (start address, length) descriptor, issues word reads on the RAM read port, absorbs the RAM's one-cycle read latency, and presents the data as a valid/ready 128-bit beat stream with a last flag toward the PCIe TX/TLP builder. It decouples RAM timing from downstream backpressure with a small credit-controlled output FIFO.

## Interface
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2); also the in-flight read credit limit
- LEN_W, 16, descriptor length width in 128-bit words
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- desc_valid  in  1  descriptor offered
- desc_ready  out  1  engine idle, descriptor accepted on desc_valid & desc_ready
- desc_addr  in  32  start word address
- desc_len  in  LEN_W  number of words to read
- ram_rd_en  out  1  RAM read strobe
- ram_rd_addr  out  32  RAM word address
- ram_rd_data  in  128  RAM read data, valid the cycle after the address was sampled
- m_valid  out  1  beat available
- m_ready  in  1  downstream accepts beat
- m_data  out  128  beat data
- m_last  out  1  final beat of descriptor
- done  out  1  one-cycle pulse, descriptor complete
- busy  out  1  engine not IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: desc_ready=1. On handshake latch addr/len; len≠0 → RUN; len=0 → stay IDLE, done pulses next cycle, no beats.
- RUN: issue read when count + inflight − pop < FIFO_DEPTH (pop = m_valid & m_ready this cycle). Issue drives ram_rd_en=1, ram_rd_addr=desc_addr+issued; issued increments. After issuing the len-th read → DRAIN.
- DRAIN: no issues; after handshake of the beat flagged last → IDLE, done=1 for one cycle.
- inflight: 1-bit, set on issue, cleared one cycle later when ram_rd_data is pushed into the FIFO. Never overflows the FIFO by construction.
- m_last tags the beat whose index equals len−1; carried through the FIFO as a 129th bit.
- Address arithmetic: 32-bit, wraps modulo 2^32 (0xFFFF_FFFF → 0x0000_0000) without error.
- Counters issued/popped are LEN_W bits; max descriptor 2^LEN_W−1 words.
- ram_rd_addr holds its last value when not issuing; ram_rd_en=0.
- desc_valid outside IDLE ignored (desc_ready=0).
- Reset at any time: FSM→IDLE, FIFO flushed, inflight dropped, counters cleared; an in-flight RAM response is discarded.

## Timing
- Reset values: desc_ready=1, ram_rd_en=0, ram_rd_addr=0, m_valid=0, m_data=0, m_last=0, done=0, busy=0.
- Edge E0 accepts descriptor; ram_rd_en=1 in cycle after E0; RAM samples at E1; FIFO writes at E2; m_valid=1 after E2.
- With m_ready held high: one beat per cycle sustained, len beats in len consecutive cycles.
- done asserted in the cycle after the last-beat handshake edge; desc_ready=1 in that same cycle; next descriptor may be accepted then (back-to-back).
- m_data/m_valid/m_last stable while m_valid & ~m_ready.

## Configuration
- DMA_RD_STATS_EN defined: adds outputs stall_cnt[31:0] (cycles with m_valid & ~m_ready) and beat_cnt[31:0] (accepted beats); both cumulative, saturate at 0xFFFF_FFFF, cleared only by reset.
- Undefined: ports and counters absent; remaining behaviour identical.

## Structure
- dma_pkg: state enum (IDLE/RUN/DRAIN), DATA_W=128, ADDR_W=32, descriptor struct {addr, len}.
- One sub-module: dma_rd_fifo (synchronous FIFO, width DATA_W+1, depth FIFO_DEPTH, count output); engine holds FSM, counters, credit logic.

## Test plan
- Reset release, addr=0x10, len=4, m_ready=1 → RAM addr 0x10..0x13 on consecutive cycles; 4 beats consecutive, m_last on 4th; done one cycle after.
- Same descriptor, m_ready low 10 cycles then high → ram_rd_en stops after FIFO_DEPTH issues; data order intact; stall_cnt=10 with DMA_RD_STATS_EN.
- len=0 → no ram_rd_en, no m_valid, done pulses once; desc_ready stays 1.
- addr=0xFFFF_FFFE, len=3 → addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Two back-to-back descriptors (len=2, len=3) → 5 beats, m_last on beats 2 and 5, two done pulses.
- rst_n low mid-RUN with FIFO half full → all outputs to reset values immediately; new descriptor afterwards returns only its own data.
